// File: rtl/chronos.sv
// Shared Chronos types and constants: virtual-time layout, tile count and GVT round timing.
package chronos;

  localparam int TS_WIDTH  = 32;
  localparam int TB_WIDTH  = 32;
  localparam int C_N_TILES = 4;

  typedef logic [TS_WIDTH+TB_WIDTH-1:0] vt_t;

  localparam int GVT_INTERVAL = 64;
  localparam int GVT_TIMEOUT  = 1024;

  typedef enum logic [1:0] {
    GVT_IDLE    = 2'd0,
    GVT_COLLECT = 2'd1,
    GVT_PUBLISH = 2'd2,
    GVT_WAIT    = 2'd3
  } gvt_state_e;

endpackage

// File: rtl/vt_min_reduce.sv
// Combinational masked minimum over N virtual times; masked-out entries and the
// power-of-two padding read as all ones, so an empty mask yields all ones.
module vt_min_reduce #(
  parameter int N = 4,
  parameter int W = 64
) (
  input  logic [N*W-1:0] vals_i,
  input  logic [N-1:0]   mask_i,
  output logic [W-1:0]   min_o
);

  localparam int LVLS = $clog2(N);
  localparam int P    = 1 << LVLS;

  logic [W-1:0] node [P];

  // Pairwise tree folded in place: level l leaves its P>>(l+1) winners in node[0..].
  always_comb begin
    for (int i = 0; i < P; i++) node[i] = '1;
    for (int i = 0; i < N; i++) begin
      if (mask_i[i]) node[i] = vals_i[i*W +: W];
    end
    for (int l = 0; l < LVLS; l++) begin
      for (int i = 0; i < (P >> (l + 1)); i++) begin
        node[i] = (node[2*i] < node[2*i+1]) ? node[2*i] : node[2*i+1];
      end
    end
    min_o = node[0];
  end

endmodule

// File: rtl/gvt_round_ctrl.sv
// Round-based GVT sequencer: polls every tile for its LVT, min-reduces the answers
// and publishes a monotonic GVT with a one-cycle strobe.
module gvt_round_ctrl
  import chronos::*;
#(
  parameter int N_TILES  = C_N_TILES,
  parameter int VT_W     = TS_WIDTH + TB_WIDTH,
  parameter int INTERVAL = GVT_INTERVAL,
  parameter int TIMEOUT  = GVT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic [N_TILES-1:0]      lvt_req,
  input  logic [N_TILES-1:0]      lvt_valid,
  input  logic [N_TILES*VT_W-1:0] lvt,
  output logic [VT_W-1:0]         gvt,
  output logic                    gvt_valid,
  output logic                    busy,
  output logic                    timeout_err,
  output logic                    regress_err,
  output logic [1:0]              state_dbg
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int IW = (INTERVAL > 2) ? $clog2(INTERVAL - 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] INT_LAST = IW'((INTERVAL >= 2) ? (INTERVAL - 2) : 0);

  gvt_state_e          state_q, state_d, gap_state;
  logic [N_TILES-1:0]  pend_q, pend_d;
  logic [VT_W-1:0]     acc_q, acc_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [IW-1:0]       int_q, int_d;
  logic [VT_W-1:0]     gvt_q, gvt_d;
  logic                gvt_valid_q, gvt_valid_d;
  logic                tmo_err_q, tmo_err_d;
  logic                reg_err_q, reg_err_d;

  logic [N_TILES-1:0]  accept, pend_left;
  logic [VT_W-1:0]     red_min, acc_min;
  logic                start_round, gap_start;
  logic                in_collect, in_publish, in_wait;

  // Handshake: lvt_req[i] is held until a cycle with lvt_req[i] & lvt_valid[i]; that
  // cycle transfers lvt[i] and the request drops on the following edge. Valid without
  // a request is ignored.
  assign accept    = pend_q & lvt_valid;
  assign pend_left = pend_q & ~accept;

  vt_min_reduce #(
    .N (N_TILES),
    .W (VT_W)
  ) u_min (
    .vals_i (lvt),
    .mask_i (accept),
    .min_o  (red_min)
  );

  assign acc_min = (red_min < acc_q) ? red_min : acc_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= GVT_IDLE;
    else     state_q <= state_d;
  end

  // After a publish or a timeout: WAIT, unless the interval is a single cycle.
  always_comb begin
    gap_state   = (INTERVAL > 1) ? GVT_WAIT : (en ? GVT_COLLECT : GVT_IDLE);
    gap_start   = (INTERVAL == 1) && en;
    state_d     = state_q;
    start_round = 1'b0;
    unique case (state_q)
      GVT_IDLE: begin
        if (en) begin
          state_d     = GVT_COLLECT;
          start_round = 1'b1;
        end
      end
      GVT_COLLECT: begin
        if (pend_left == '0) begin
          state_d = GVT_PUBLISH;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = gap_state;
          start_round = gap_start;
        end
      end
      GVT_PUBLISH: begin
        state_d     = gap_state;
        start_round = gap_start;
      end
      GVT_WAIT: begin
        if (int_q == INT_LAST) begin
          state_d     = en ? GVT_COLLECT : GVT_IDLE;
          start_round = en;
        end
      end
    endcase
  end

  always_comb begin
    busy       = (state_q != GVT_IDLE);
    in_collect = (state_q == GVT_COLLECT);
    in_publish = (state_q == GVT_PUBLISH);
    in_wait    = (state_q == GVT_WAIT);
    state_dbg  = state_q;
  end

  always_comb begin
    pend_d      = pend_q;
    acc_d       = acc_q;
    tmo_d       = tmo_q;
    int_d       = in_wait ? int_q + IW'(1) : '0;
    gvt_d       = gvt_q;
    gvt_valid_d = 1'b0;
    tmo_err_d   = tmo_err_q;
    reg_err_d   = reg_err_q;
    if (in_collect) begin
      pend_d = pend_left;
      acc_d  = acc_min;
      tmo_d  = tmo_q + TW'(1);
      // A final accept in the timeout cycle completes the round instead.
      if (pend_left != '0 && tmo_q == TMO_LAST) begin
        pend_d    = '0;
        acc_d     = '1;
        tmo_err_d = 1'b1;
      end
    end
    if (in_publish) begin
      if (acc_q >= gvt_q) begin
        gvt_d       = acc_q;
        gvt_valid_d = 1'b1;
      end else begin
        reg_err_d = 1'b1;
      end
    end
    if (start_round) begin
      pend_d = '1;
      acc_d  = '1;
      tmo_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      acc_q       <= '1;
      tmo_q       <= '0;
      int_q       <= '0;
      gvt_q       <= '0;
      gvt_valid_q <= 1'b0;
      tmo_err_q   <= 1'b0;
      reg_err_q   <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      acc_q       <= acc_d;
      tmo_q       <= tmo_d;
      int_q       <= int_d;
      gvt_q       <= gvt_d;
      gvt_valid_q <= gvt_valid_d;
      tmo_err_q   <= tmo_err_d;
      reg_err_q   <= reg_err_d;
    end
  end

  assign lvt_req     = pend_q;
  assign gvt         = gvt_q;
  assign gvt_valid   = gvt_valid_q;
  assign timeout_err = tmo_err_q;
  assign regress_err = reg_err_q;

endmodule

// File: tb/tb_gvt_round_ctrl.sv
// Bench for gvt_round_ctrl: directed multi-cycle sequences, a table of whole rounds,
// and a randomized stress phase scored against a round-level model.
module tb_gvt_round_ctrl;

  localparam int N        = 4;
  localparam int W        = 64;
  localparam int INTERVAL = 8;
  localparam int TIMEOUT  = 16;
  localparam int N_STRESS = 3000;

  logic           clk = 1'b0;
  logic           rst, en;
  logic [N-1:0]   lvt_req, lvt_valid;
  logic [N*W-1:0] lvt;
  logic [W-1:0]   gvt;
  logic           gvt_valid, busy, timeout_err, regress_err;
  logic [1:0]     state_dbg;

  gvt_round_ctrl #(
    .N_TILES  (N),
    .VT_W     (W),
    .INTERVAL (INTERVAL),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .lvt_req     (lvt_req),
    .lvt_valid   (lvt_valid),
    .lvt         (lvt),
    .gvt         (gvt),
    .gvt_valid   (gvt_valid),
    .busy        (busy),
    .timeout_err (timeout_err),
    .regress_err (regress_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en        = 1'b0;
    lvt_valid = '0;
    lvt       = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_tile(input int i, input logic [W-1:0] v);
    lvt_valid[i]    = 1'b1;
    lvt[i*W +: W]   = v;
  endtask

  task automatic wait_all_req();
    for (int c = 0; c < 200; c++) begin
      if (lvt_req == 4'hF) break;
      tick();
    end
    check("round_start", 64'(lvt_req), 64'hF);
  endtask

  // ---------------- table of whole rounds ----------------
  typedef struct packed {
    logic                rst_first;
    logic                simul;
    logic [N-1:0][W-1:0] v;
    logic [W-1:0]        exp_gvt;
    logic                exp_pulse;
    logic                exp_reg;
  } rec_t;

  function automatic rec_t mk(input logic rf, input logic sim,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] c, input logic [W-1:0] d,
                              input logic [W-1:0] eg, input logic ep, input logic er);
    rec_t r;
    r.rst_first = rf;
    r.simul     = sim;
    r.v[0]      = a;
    r.v[1]      = b;
    r.v[2]      = c;
    r.v[3]      = d;
    r.exp_gvt   = eg;
    r.exp_pulse = ep;
    r.exp_reg   = er;
    return r;
  endfunction

  task automatic run_round(input rec_t r);
    int pulses, pulse_at;
    logic [N-1:0] m;
    if (r.rst_first) do_reset();
    en = 1'b1;
    wait_all_req();
    if (r.simul) begin
      for (int i = 0; i < N; i++) set_tile(i, r.v[i]);
      tick();
      lvt_valid = '0;
      check("req_after_simul", 64'(lvt_req), 64'd0);
    end else begin
      for (int i = 0; i < N; i++) begin
        lvt_valid = '0;
        set_tile(i, r.v[i]);
        tick();
        m = 4'hF;
        m = m << (i + 1);
        check("req_progress", 64'(lvt_req), 64'(m));
      end
      lvt_valid = '0;
    end
    pulses   = 0;
    pulse_at = -1;
    for (int k = 1; k <= 9; k++) begin
      if (gvt_valid) begin
        pulses++;
        pulse_at = k;
      end
      if (k == 8) check("req_gap", 64'(lvt_req), 64'd0);
      if (k == 9) check("next_round_req", 64'(lvt_req), 64'hF);
      if (k < 9) tick();
    end
    check("pulse_count", 64'(pulses), 64'(r.exp_pulse));
    if (r.exp_pulse) check("pulse_latency", 64'(pulse_at), 64'd2);
    check("round_gvt", gvt, r.exp_gvt);
    check("round_regress", 64'(regress_err), 64'(r.exp_reg));
  endtask

  // ---------------- stress: model + scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_gvt, last_gvt, rmin;
  logic         model_reg;
  int           got, rounds;
  int           waitc[N];
  logic [N-1:0] prev_req, prev_valid;

  task automatic stress_cycle();
    logic [W-1:0] v, e;
    tick();
    for (int i = 0; i < N; i++) begin
      if (prev_req[i]) begin
        if (prev_valid[i]) check("req_drop", 64'(lvt_req[i]), 64'd0);
        else               check("req_hold", 64'(lvt_req[i]), 64'd1);
      end
    end
    if (gvt_valid) begin
      if (exp_q.size() == 0) begin
        check("pending_publishes", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("stress_gvt", gvt, e);
        check("gvt_monotonic", 64'(gvt >= last_gvt), 64'd1);
      end
      last_gvt = gvt;
    end
    lvt_valid = '0;
    for (int i = 0; i < N; i++) begin
      if (lvt_req[i]) begin
        waitc[i]++;
        if ($urandom_range(0, 1) == 1 || waitc[i] >= 6) begin
          v = model_gvt + 64'($urandom_range(0, 300));
          if ($urandom_range(0, 39) == 0 && model_gvt >= 64)
            v = model_gvt - 64'($urandom_range(1, 50));
          set_tile(i, v);
          if (v < rmin) rmin = v;
          got++;
          waitc[i] = 0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        set_tile(i, '0);
      end
    end
    if (got == N) begin
      rounds++;
      if (rmin >= model_gvt) begin
        exp_q.push_back(rmin);
        model_gvt = rmin;
      end else begin
        model_reg = 1'b1;
      end
      got  = 0;
      rmin = '1;
    end
    prev_req   = lvt_req;
    prev_valid = lvt_valid;
  endtask

  // ---------------- test sequence ----------------
  rec_t tbl[9];

  initial begin
    int pulses;
    logic any;

    tbl[0] = mk(1'b1, 1'b0, 64'd50,  64'd20,  64'd90,  64'd35,  64'd20,  1'b1, 1'b0);
    tbl[1] = mk(1'b1, 1'b1, 64'd7,   64'd3,   64'd3,   64'd9,   64'd3,   1'b1, 1'b0);
    tbl[2] = mk(1'b1, 1'b0, 64'd100, 64'd150, 64'd200, 64'd250, 64'd100, 1'b1, 1'b0);
    tbl[3] = mk(1'b0, 1'b0, 64'd80,  64'd120, 64'd130, 64'd140, 64'd100, 1'b0, 1'b1);
    tbl[4] = mk(1'b0, 1'b1, 64'd300, 64'd101, 64'd500, 64'd400, 64'd101, 1'b1, 1'b1);
    tbl[5] = mk(1'b1, 1'b1, '1, '1, '1, '1, '1, 1'b1, 1'b0);
    tbl[6] = mk(1'b0, 1'b0, 64'd5,   64'd5,   64'd5,   64'd5,   '1,      1'b0, 1'b1);
    tbl[7] = mk(1'b1, 1'b1, 64'd0,   64'd0,   64'd0,   64'd0,   64'd0,   1'b1, 1'b0);
    tbl[8] = mk(1'b0, 1'b0, 64'd0,   64'd9,   64'd4,   64'd2,   64'd0,   1'b1, 1'b0);

    // Reset state
    do_reset();
    check("rst_gvt",       gvt,                 64'd0);
    check("rst_gvt_valid", 64'(gvt_valid),      64'd0);
    check("rst_req",       64'(lvt_req),        64'd0);
    check("rst_busy",      64'(busy),           64'd0);
    check("rst_terr",      64'(timeout_err),    64'd0);
    check("rst_rerr",      64'(regress_err),    64'd0);
    check("rst_state",     64'(state_dbg),      64'd0);

    // Timeout: tile 2 never answers
    en = 1'b1;
    wait_all_req();
    set_tile(0, 64'd5);
    set_tile(1, 64'd6);
    set_tile(3, 64'd7);
    pulses = 0;
    for (int s = 1; s <= 23; s++) begin
      tick();
      lvt_valid = '0;
      if (gvt_valid) pulses++;
      if (s == 15) begin
        check("tmo_pre_err", 64'(timeout_err), 64'd0);
        check("tmo_pre_req", 64'(lvt_req),     64'h4);
      end
      if (s == 16) begin
        check("tmo_err",  64'(timeout_err), 64'd1);
        check("tmo_req",  64'(lvt_req),     64'd0);
        check("tmo_busy", 64'(busy),        64'd1);
      end
      if (s == 22) check("tmo_gap_req",  64'(lvt_req), 64'd0);
      if (s == 23) check("tmo_next_req", 64'(lvt_req), 64'hF);
    end
    check("tmo_no_pulse", 64'(pulses), 64'd0);
    check("tmo_gvt",      gvt,         64'd0);
    for (int i = 0; i < N; i++) set_tile(i, 64'(i + 1));
    tick();
    lvt_valid = '0;
    tick();
    check("after_tmo_pulse", 64'(gvt_valid),   64'd1);
    check("after_tmo_gvt",   gvt,              64'd1);
    check("tmo_sticky",      64'(timeout_err), 64'd1);

    // Final accept coincident with the timeout cycle
    do_reset();
    en = 1'b1;
    wait_all_req();
    set_tile(0, 64'd40);
    set_tile(1, 64'd50);
    set_tile(3, 64'd60);
    for (int s = 1; s <= 15; s++) begin
      tick();
      if (s == 1) lvt_valid = '0;
    end
    check("coin_pre_req", 64'(lvt_req), 64'h4);
    set_tile(2, 64'd30);
    tick();
    lvt_valid = '0;
    check("coin_terr", 64'(timeout_err), 64'd0);
    check("coin_req",  64'(lvt_req),     64'd0);
    tick();
    check("coin_pulse", 64'(gvt_valid), 64'd1);
    check("coin_gvt",   gvt,            64'd30);

    // Reset mid-COLLECT after two accepts
    wait_all_req();
    set_tile(0, 64'd35);
    set_tile(1, 64'd36);
    tick();
    lvt_valid = '0;
    check("midrst_req_before", 64'(lvt_req), 64'hC);
    rst = 1'b1;
    en  = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_gvt",   gvt,                64'd0);
    check("midrst_req",   64'(lvt_req),       64'd0);
    check("midrst_busy",  64'(busy),          64'd0);
    check("midrst_state", 64'(state_dbg),     64'd0);
    pulses = 0;
    any    = 1'b0;
    for (int s = 0; s < 20; s++) begin
      tick();
      if (gvt_valid) pulses++;
      any = any | busy;
    end
    check("midrst_no_pulse", 64'(pulses), 64'd0);
    check("midrst_idle",     64'(any),    64'd0);

    // en dropped mid-round: the round still publishes, then IDLE
    en = 1'b1;
    wait_all_req();
    en = 1'b0;
    for (int i = 0; i < N; i++) set_tile(i, 64'(70 + i));
    tick();
    lvt_valid = '0;
    tick();
    check("endrop_pulse", 64'(gvt_valid), 64'd1);
    check("endrop_gvt",   gvt,            64'd70);
    for (int s = 3; s <= 9; s++) begin
      tick();
      if (s == 8) check("endrop_busy_wait", 64'(busy), 64'd1);
      if (s == 9) begin
        check("endrop_busy_idle", 64'(busy),      64'd0);
        check("endrop_state",     64'(state_dbg), 64'd0);
      end
    end
    any = 1'b0;
    for (int s = 0; s < 12; s++) begin
      tick();
      any = any | (|lvt_req);
    end
    check("endrop_no_req", 64'(any), 64'd0);

    // Table-driven rounds
    for (int t = 0; t < 9; t++) run_round(tbl[t]);
    en = 1'b0;

    // Random stress
    do_reset();
    model_gvt  = '0;
    last_gvt   = '0;
    rmin       = '1;
    model_reg  = 1'b0;
    got        = 0;
    rounds     = 0;
    prev_req   = '0;
    prev_valid = '0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    exp_q.delete();
    en = 1'b1;
    for (int c = 0; c < 60000 && rounds < N_STRESS; c++) stress_cycle();
    en = 1'b0;
    for (int c = 0; c < 40; c++) stress_cycle();
    check("stress_rounds",  64'(rounds >= N_STRESS), 64'd1);
    check("stress_drained", 64'(exp_q.size()),       64'd0);
    check("stress_busy",    64'(busy),               64'd0);
    check("stress_gvt_end", gvt,                     model_gvt);
    check("stress_rerr",    64'(regress_err),        64'(model_reg));
    check("stress_terr",    64'(timeout_err),        64'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
